// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and scan-code constants for the PS/2 keyboard controller
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE  = 2'd1,
        ST_PFX   = 2'd2,
        ST_PAUSE = 2'd3
    } ps2_state_t;

    localparam int EVT_W = 10;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_E1 = 8'hE1;
    localparam logic [7:0] CODE_AA = 8'hAA;
    localparam logic [7:0] CODE_FC = 8'hFC;
    localparam logic [7:0] CODE_FA = 8'hFA;
    localparam logic [7:0] CODE_FE = 8'hFE;
    localparam logic [7:0] CODE_00 = 8'h00;
    localparam logic [7:0] CODE_FF = 8'hFF;

    // Bytes following the E1 that opens the Pause/Break make sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic is_status(input logic [7:0] code);
        return (code == CODE_AA) || (code == CODE_FC) || (code == CODE_00) ||
               (code == CODE_FF) || (code == CODE_FA) || (code == CODE_FE);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - synchronous event FIFO; a push into a full FIFO is dropped unless a pop frees a slot
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head reads as zero while empty so the output never exposes stale entries
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - scan-code-set-2 sequencer turning received bytes into queued key events and status pulses
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_wait,
    output logic [EVT_W-1:0] evt_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             bat_ok,
    output logic             bat_fail,
    output logic             dev_ovr,
    output logic             ack_seen,
    output logic             fifo_ovf,
    input  logic             ovf_clr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t       state, state_next;
    logic             ext, ext_next;
    logic             brk, brk_next;
    logic [2:0]       skip, skip_next;
    logic [TW-1:0]    tmo_cnt, tmo_next;
    logic             tmo_hit;
    logic             evt_push;
    logic [EVT_W-1:0] evt_push_data;
    logic             evt_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovf_set;
    logic             bat_ok_next, bat_fail_next, dev_ovr_next, ack_seen_next;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_comb begin
        state_next    = state;
        ext_next      = ext;
        brk_next      = brk;
        skip_next     = skip;
        tmo_next      = '0;
        evt_push      = 1'b0;
        evt_push_data = '0;
        bat_ok_next   = 1'b0;
        bat_fail_next = 1'b0;
        dev_ovr_next  = 1'b0;
        ack_seen_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_BYTE;
                end
            end

            ST_BYTE, ST_PFX: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    ext_next   = 1'b0;
                    brk_next   = 1'b0;
                    skip_next  = '0;
                end else if (rx_valid) begin
                    if (rx_data == CODE_E0) begin
                        ext_next   = 1'b1;
                        state_next = ST_PFX;
                    end else if (rx_data == CODE_F0) begin
                        brk_next   = 1'b1;
                        state_next = ST_PFX;
                    end else if (state == ST_BYTE && rx_data == CODE_E1) begin
                        skip_next  = PAUSE_SKIP;
                        state_next = ST_PAUSE;
                    end else if (state == ST_BYTE && is_status(rx_data)) begin
                        // Device status bytes are only meaningful outside a prefixed sequence
                        bat_ok_next   = (rx_data == CODE_AA);
                        bat_fail_next = (rx_data == CODE_FC);
                        dev_ovr_next  = (rx_data == CODE_00) || (rx_data == CODE_FF);
                        ack_seen_next = (rx_data == CODE_FA) || (rx_data == CODE_FE);
                    end else begin
                        evt_push      = 1'b1;
                        evt_push_data = {brk, ext, rx_data};
                        ext_next      = 1'b0;
                        brk_next      = 1'b0;
                        state_next    = ST_BYTE;
                    end
                end else if (state == ST_PFX) begin
                    if (tmo_hit) begin
                        ext_next   = 1'b0;
                        brk_next   = 1'b0;
                        state_next = ST_BYTE;
                    end else begin
                        tmo_next = tmo_cnt + 1'b1;
                    end
                end
            end

            ST_PAUSE: begin
                if (rx_valid) begin
                    if (skip == 3'd1) begin
                        evt_push      = 1'b1;
                        evt_push_data = {1'b0, 1'b1, CODE_E1};
                        skip_next     = '0;
                        state_next    = ST_BYTE;
                    end else begin
                        skip_next = skip - 1'b1;
                    end
                end else if (tmo_hit) begin
                    skip_next  = '0;
                    state_next = ST_BYTE;
                end else begin
                    tmo_next = tmo_cnt + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                ext_next   = 1'b0;
                brk_next   = 1'b0;
                skip_next  = '0;
            end
        endcase
    end

    assign evt_valid = ~fifo_empty;
    assign evt_pop   = evt_valid & evt_ready;
    assign ovf_set   = evt_push & fifo_full & ~evt_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ext      <= 1'b0;
            brk      <= 1'b0;
            skip     <= '0;
            tmo_cnt  <= '0;
            rx_wait  <= 1'b0;
            bat_ok   <= 1'b0;
            bat_fail <= 1'b0;
            dev_ovr  <= 1'b0;
            ack_seen <= 1'b0;
            fifo_ovf <= 1'b0;
        end else begin
            state    <= state_next;
            ext      <= ext_next;
            brk      <= brk_next;
            skip     <= skip_next;
            tmo_cnt  <= tmo_next;
            rx_wait  <= (state_next != ST_IDLE);
            bat_ok   <= bat_ok_next;
            bat_fail <= bat_fail_next;
            dev_ovr  <= dev_ovr_next;
            ack_seen <= ack_seen_next;
            // A fresh overflow outranks a clear in the same cycle
            if (ovf_set) begin
                fifo_ovf <= 1'b1;
            end else if (ovf_clr) begin
                fifo_ovf <= 1'b0;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_evt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (evt_push),
        .push_data (evt_push_data),
        .pop       (evt_pop),
        .pop_data  (evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - self-checking bench for ps2_kbd_ctrl against a timestamp-based sequence model
module tb_ps2_kbd_ctrl;

    localparam int T = 40;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       rx_wait;
    logic [9:0] evt_data;
    logic       evt_valid;
    logic       bat_ok, bat_fail, dev_ovr, ack_seen, fifo_ovf;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: pending prefixes, pause bytes still to swallow, time of last byte
    logic [9:0] mq[$];
    bit m_armed, m_ext, m_brk, m_ovf;
    int m_skip, m_last;
    bit e_bat_ok, e_bat_fail, e_dev_ovr, e_ack;

    ps2_kbd_ctrl #(
        .TIMEOUT_CYCLES (T),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_wait   (rx_wait),
        .evt_data  (evt_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .bat_ok    (bat_ok),
        .bat_fail  (bat_fail),
        .dev_ovr   (dev_ovr),
        .ack_seen  (ack_seen),
        .fifo_ovf  (fifo_ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_status(input logic [7:0] b);
        return b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF || b == 8'hFA || b == 8'hFE;
    endfunction

    task automatic model_edge();
        bit popped;
        bit push;
        logic [9:0] pd;
        push = 1'b0;
        pd = '0;
        e_bat_ok = 0; e_bat_fail = 0; e_dev_ovr = 0; e_ack = 0;
        if (reset) begin
            mq.delete();
            m_armed = 0; m_ext = 0; m_brk = 0; m_skip = 0; m_ovf = 0; m_last = cyc;
            return;
        end
        popped = (mq.size() != 0) && evt_ready;
        if (!m_armed) begin
            m_armed = enable;
        end else if (m_skip == 0 && !enable) begin
            m_armed = 0; m_ext = 0; m_brk = 0;
        end else if (rx_valid) begin
            m_last = cyc;
            if (m_skip != 0) begin
                m_skip--;
                if (m_skip == 0) begin
                    push = 1; pd = 10'h1E1;
                end
            end else if (rx_data == 8'hE0) begin
                m_ext = 1;
            end else if (rx_data == 8'hF0) begin
                m_brk = 1;
            end else if (!m_ext && !m_brk && rx_data == 8'hE1) begin
                m_skip = 7;
            end else if (!m_ext && !m_brk && is_status(rx_data)) begin
                e_bat_ok   = (rx_data == 8'hAA);
                e_bat_fail = (rx_data == 8'hFC);
                e_dev_ovr  = (rx_data == 8'h00) || (rx_data == 8'hFF);
                e_ack      = (rx_data == 8'hFA) || (rx_data == 8'hFE);
            end else begin
                push = 1; pd = {m_brk, m_ext, rx_data};
                m_ext = 0; m_brk = 0;
            end
        end else if ((m_ext || m_brk || m_skip != 0) && (cyc - m_last >= T)) begin
            m_ext = 0; m_brk = 0; m_skip = 0;
        end
        if (popped) void'(mq.pop_front());
        if (push) begin
            if (mq.size() >= D) m_ovf = 1;
            else mq.push_back(pd);
        end else if (ovf_clr) begin
            m_ovf = 0;
        end
    endtask

    task automatic check_all();
        logic [9:0] head;
        head = (mq.size() != 0) ? mq[0] : 10'h000;
        check("rx_wait",   16'(rx_wait),   16'(m_armed));
        check("evt_valid", 16'(evt_valid), 16'(mq.size() != 0));
        check("evt_data",  16'(evt_data),  16'(head));
        check("bat_ok",    16'(bat_ok),    16'(e_bat_ok));
        check("bat_fail",  16'(bat_fail),  16'(e_bat_fail));
        check("dev_ovr",   16'(dev_ovr),   16'(e_dev_ovr));
        check("ack_seen",  16'(ack_seen),  16'(e_ack));
        check("fifo_ovf",  16'(fifo_ovf),  16'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (idle) tick();
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        repeat (D + 2) tick();
        evt_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        logic [7:0] keys [5];
        logic [7:0] b;
        int r;
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        keys = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};

        repeat (3) tick();
        check("rst_rx_wait", 16'(rx_wait), 16'h0);
        check("rst_evt_valid", 16'(evt_valid), 16'h0);
        check("rst_evt_data", 16'(evt_data), 16'h0);
        reset = 1'b0;
        enable = 1'b1;
        tick();
        check("arm_rx_wait", 16'(rx_wait), 16'h1);

        // Plain make then break
        send_byte(8'h1C, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h1C, 0);
        check("t1_head0", 16'(evt_data), 16'h01C);
        evt_ready = 1'b1;
        tick();
        check("t1_head1", 16'(evt_data), 16'h21C);
        tick();
        check("t1_empty", 16'(evt_valid), 16'h0);
        evt_ready = 1'b0;

        // Extended break
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        check("t2_no_pfx_evt", 16'(evt_valid), 16'h0);
        send_byte(8'h75, 0);
        check("t2_head", 16'(evt_data), 16'h375);
        drain();

        // Pause sequence collapses to one event
        for (int i = 0; i < 8; i++) begin
            send_byte(pause_seq[i], 0);
            if (i == 6) check("t3_no_early", 16'(evt_valid), 16'h0);
        end
        check("t3_head", 16'(evt_data), 16'h1E1);
        drain();
        send_byte(8'h1C, 0);
        check("t3_after", 16'(evt_data), 16'h01C);
        drain();

        // Prefix timeout: one cycle past the limit drops ext, at the limit keeps it
        send_byte(8'hE0, T);
        check("t4_no_evt", 16'(evt_valid), 16'h0);
        send_byte(8'h1C, 0);
        check("t4_timed_out", 16'(evt_data), 16'h01C);
        drain();
        send_byte(8'hE0, T - 1);
        send_byte(8'h1C, 0);
        check("t4_in_time", 16'(evt_data), 16'h11C);
        drain();

        // Overflow
        for (int i = 0; i < 5; i++) send_byte(keys[i], 0);
        check("t5_ovf", 16'(fifo_ovf), 16'h1);
        check("t5_head", 16'(evt_data), 16'h01C);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_ovf_clr", 16'(fifo_ovf), 16'h0);
        drain();

        // Status bytes
        send_byte(8'hAA, 0);
        check("t6_bat_ok", 16'(bat_ok), 16'h1);
        check("t6_no_evt", 16'(evt_valid), 16'h0);
        tick();
        check("t6_bat_ok_low", 16'(bat_ok), 16'h0);
        send_byte(8'hFC, 0); send_byte(8'h00, 0); send_byte(8'hFF, 0);
        send_byte(8'hFA, 0); send_byte(8'hFE, 1);
        send_byte(8'hF0, 0);
        send_byte(8'hAA, 0);
        check("t6_brk_aa", 16'(evt_data), 16'h2AA);
        drain();

        // Disable mid-prefix clears flags
        send_byte(8'hE0, 0);
        enable = 1'b0;
        tick(); tick();
        check("t7_disarm", 16'(rx_wait), 16'h0);
        enable = 1'b1;
        tick();
        send_byte(8'h1C, 0);
        check("t7_flags_gone", 16'(evt_data), 16'h01C);
        drain();

        // Reset mid-prefix with a queued event
        send_byte(8'h1C, 0);
        send_byte(8'hE0, 0);
        reset = 1'b1;
        tick();
        check("t8_rx_wait", 16'(rx_wait), 16'h0);
        check("t8_evt_valid", 16'(evt_valid), 16'h0);
        check("t8_evt_data", 16'(evt_data), 16'h0);
        reset = 1'b0;
        tick();

        // Randomized byte stream
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
                3: b = is_status(8'($urandom_range(0, 255))) ? 8'hAA : 8'hFA;
                4: b = ($urandom_range(0, 1) != 0) ? 8'hFC : 8'h00;
                5: b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hFE;
                default: b = 8'($urandom_range(0, 255));
            endcase
            evt_ready = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 19);
            if (r == 0) send_byte(b, T - 1);
            else if (r == 1) send_byte(b, T);
            else send_byte(b, $urandom_range(0, 3));
            ovf_clr = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
